// File: rtl/weight_mem_fifo_ctrl_pkg.sv
// Shared constants, sequencer state encodings and the counter-width helper
// for the weight memory / FIFO controller.
package weight_mem_fifo_ctrl_pkg;

    localparam int DEF_FIFO_WIDTH = 16;
    localparam int DEF_FIFO_DEPTH = 16;
    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_ADDR_WIDTH = 8;

    // Enough bits to hold 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    typedef enum logic [1:0] {
        FILL_IDLE  = 2'd0,
        FILL_READ  = 2'd1,
        FILL_FLUSH = 2'd2
    } fill_state_e;

    typedef enum logic [1:0] {
        DRAIN_IDLE  = 2'd0,
        DRAIN_SHIFT = 2'd1,
        DRAIN_TAIL  = 2'd2,
        DRAIN_DONE  = 2'd3
    } drain_state_e;

endpackage

// File: rtl/weight_mem_fifo_ctrl_if.sv
// Host-side bundle of the weight memory controller: sequence pulses, bank
// write port, read data and the FIFO / array strobes.
interface weight_mem_fifo_ctrl_if import weight_mem_fifo_ctrl_pkg::*; #(
    parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
    logic                                  in_en;
    logic                                  out_en;
    logic [FIFO_WIDTH-1:0]                 wr_en;
    logic [FIFO_WIDTH-1:0][ADDR_WIDTH-1:0] wr_addr;
    logic [FIFO_WIDTH-1:0][DATA_WIDTH-1:0] wr_data;
    logic [FIFO_WIDTH-1:0][DATA_WIDTH-1:0] rd_data;
    logic [FIFO_WIDTH-1:0]                 fifo_in_en;
    logic [FIFO_WIDTH-1:0]                 fifo_out_en;
    logic [FIFO_WIDTH-1:0]                 w_wen;
    logic                                  done;
    logic                                  busy_in;
    logic                                  busy_out;

    modport master (
        output in_en, out_en, wr_en, wr_addr, wr_data,
        input  rd_data, fifo_in_en, fifo_out_en, w_wen, done, busy_in, busy_out
    );

    modport slave (
        input  in_en, out_en, wr_en, wr_addr, wr_data,
        output rd_data, fifo_in_en, fifo_out_en, w_wen, done, busy_in, busy_out
    );
endinterface

// File: rtl/weight_mem_fifo_ctrl_fifo_in_ctrl.sv
// Fill sequencer: reads addresses 0..FIFO_DEPTH-1 from all banks and shifts
// each returned word into the weight FIFO one cycle later.
module fifo_in_ctrl import weight_mem_fifo_ctrl_pkg::*; #(
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  in_en,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  fifo_in_en,
    output logic                  busy
);
    localparam int              CW   = cnt_width(FIFO_DEPTH);
    localparam logic [CW-1:0]   LAST = CW'(FIFO_DEPTH - 1);

    fill_state_e           state_r, state_s;
    logic [CW-1:0]         cnt_r, cnt_s;
    logic                  rd_en_s, busy_s;
    logic [ADDR_WIDTH-1:0] rd_addr_s;

    // State register with registered strobes; FIFO shift trails the read by one cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r    <= FILL_IDLE;
            cnt_r      <= {CW{1'b0}};
            rd_en      <= 1'b0;
            rd_addr    <= {ADDR_WIDTH{1'b0}};
            fifo_in_en <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            rd_en      <= rd_en_s;
            rd_addr    <= rd_addr_s;
            fifo_in_en <= rd_en;
            busy       <= busy_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            FILL_IDLE: begin
                if (in_en) begin
                    state_s = FILL_READ;
                    cnt_s   = {CW{1'b0}};
                end else begin
                    state_s = FILL_IDLE;
                end
            end
            FILL_READ: begin
                if (cnt_r == LAST) begin
                    state_s = FILL_FLUSH;
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
            end
            FILL_FLUSH: begin
                state_s = FILL_IDLE;
                cnt_s   = {CW{1'b0}};
            end
            default: begin
                state_s = FILL_IDLE;
                cnt_s   = {CW{1'b0}};
            end
        endcase
    end

    // Output decode from the next state, registered above.
    always_comb begin
        rd_en_s   = (state_s == FILL_READ);
        rd_addr_s = ADDR_WIDTH'(cnt_s);
        busy_s    = (state_s != FILL_IDLE);
    end
endmodule

// File: rtl/weight_mem_fifo_ctrl_fifo_out_ctrl.sv
// Drain sequencer: shifts the FIFO for FIFO_DEPTH cycles, strobes the array
// one cycle behind each shift and pulses done after the final strobe.
module fifo_out_ctrl import weight_mem_fifo_ctrl_pkg::*; #(
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic clk,
    input  logic rstn,
    input  logic out_en,
    output logic fifo_out_en,
    output logic w_wen,
    output logic done,
    output logic busy
);
    localparam int            CW   = cnt_width(FIFO_DEPTH);
    localparam logic [CW-1:0] LAST = CW'(FIFO_DEPTH - 1);

    drain_state_e  state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic          shift_s, done_s, busy_s;

    // State register with registered strobes; array write trails the FIFO shift.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r     <= DRAIN_IDLE;
            cnt_r       <= {CW{1'b0}};
            fifo_out_en <= 1'b0;
            w_wen       <= 1'b0;
            done        <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            fifo_out_en <= shift_s;
            w_wen       <= fifo_out_en;
            done        <= done_s;
            busy        <= busy_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            DRAIN_IDLE: begin
                if (out_en) begin
                    state_s = DRAIN_SHIFT;
                    cnt_s   = {CW{1'b0}};
                end else begin
                    state_s = DRAIN_IDLE;
                end
            end
            DRAIN_SHIFT: begin
                if (cnt_r == LAST) begin
                    state_s = DRAIN_TAIL;
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
            end
            DRAIN_TAIL: begin
                state_s = DRAIN_DONE;
                cnt_s   = {CW{1'b0}};
            end
            DRAIN_DONE: begin
                state_s = DRAIN_IDLE;
            end
            default: begin
                state_s = DRAIN_IDLE;
                cnt_s   = {CW{1'b0}};
            end
        endcase
    end

    // Output decode from the next state, registered above.
    always_comb begin
        shift_s = (state_s == DRAIN_SHIFT);
        done_s  = (state_s == DRAIN_DONE);
        busy_s  = (state_s != DRAIN_IDLE);
    end
endmodule

// File: rtl/weight_mem_fifo_ctrl_mem_arr.sv
// Weight banks: one synchronous write port per bank and a shared-address
// read port with one cycle latency and read-before-write behaviour.
module mem_arr import weight_mem_fifo_ctrl_pkg::*; #(
    parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                                  clk,
    input  logic                                  rstn,
    input  logic [FIFO_WIDTH-1:0]                 wr_en,
    input  logic [FIFO_WIDTH-1:0][ADDR_WIDTH-1:0] wr_addr,
    input  logic [FIFO_WIDTH-1:0][DATA_WIDTH-1:0] wr_data,
    input  logic                                  rd_en,
    input  logic [ADDR_WIDTH-1:0]                 rd_addr,
    output logic [FIFO_WIDTH-1:0][DATA_WIDTH-1:0] rd_data
);
    for (genvar b = 0; b < FIFO_WIDTH; b++) begin : g_bank
        logic [DATA_WIDTH-1:0] mem_r [2**ADDR_WIDTH];
        logic [DATA_WIDTH-1:0] rd_r;

        // Bank write; storage is intentionally left out of reset.
        always_ff @(posedge clk) begin
            if (wr_en[b]) begin
                mem_r[wr_addr[b]] <= wr_data[b];
            end
        end

        // Registered read; sees the pre-write word on a same-address collision.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                rd_r <= {DATA_WIDTH{1'b0}};
            end else if (rd_en) begin
                rd_r <= mem_r[rd_addr];
            end else begin
                rd_r <= rd_r;
            end
        end

        assign rd_data[b] = rd_r;
    end
endmodule

// File: rtl/weight_mem_fifo_ctrl.sv
// Weight memory to FIFO controller: banked weight store plus independent
// fill and drain sequencers feeding the systolic array.
module weight_mem_fifo_ctrl import weight_mem_fifo_ctrl_pkg::*; #(
    parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic               clk,
    input  logic               rstn,
    weight_mem_fifo_ctrl_if.slave bus
);
    logic                  fill_rd_en;
    logic [ADDR_WIDTH-1:0] fill_rd_addr;
    logic                  fill_shift;
    logic                  drain_shift;
    logic                  drain_wen;

    mem_arr #(
        .FIFO_WIDTH (FIFO_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem_arr (
        .clk     (clk),
        .rstn    (rstn),
        .wr_en   (bus.wr_en),
        .wr_addr (bus.wr_addr),
        .wr_data (bus.wr_data),
        .rd_en   (fill_rd_en),
        .rd_addr (fill_rd_addr),
        .rd_data (bus.rd_data)
    );

    fifo_in_ctrl #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_fifo_in_ctrl (
        .clk        (clk),
        .rstn       (rstn),
        .in_en      (bus.in_en),
        .rd_en      (fill_rd_en),
        .rd_addr    (fill_rd_addr),
        .fifo_in_en (fill_shift),
        .busy       (bus.busy_in)
    );

    fifo_out_ctrl #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo_out_ctrl (
        .clk         (clk),
        .rstn        (rstn),
        .out_en      (bus.out_en),
        .fifo_out_en (drain_shift),
        .w_wen       (drain_wen),
        .done        (bus.done),
        .busy        (bus.busy_out)
    );

    // All columns move in lockstep, so one strobe fans out to every column.
    assign bus.fifo_in_en  = {FIFO_WIDTH{fill_shift}};
    assign bus.fifo_out_en = {FIFO_WIDTH{drain_shift}};
    assign bus.w_wen       = {FIFO_WIDTH{drain_wen}};
endmodule

// File: tb/tb_weight_mem_fifo_ctrl.sv
// Scoreboard bench: stimulus pushes per-cycle expectations and read data
// computed from a timeline/array model; a negedge monitor pops and compares.
module tb_weight_mem_fifo_ctrl;
    import weight_mem_fifo_ctrl_pkg::*;

    localparam int FW = 16;
    localparam int FD = 16;
    localparam int DW = 16;
    localparam int AW = 8;

    typedef logic [FW-1:0][AW-1:0] addr_vec_t;
    typedef logic [FW-1:0][DW-1:0] data_vec_t;
    typedef struct {
        bit fin, fout, wwen, done, bin, bout, rst;
    } exp_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    weight_mem_fifo_ctrl_if #(.FIFO_WIDTH(FW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    weight_mem_fifo_ctrl #(
        .FIFO_WIDTH (FW),
        .FIFO_DEPTH (FD),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int fill_s  = -1000;
    int drain_s = -1000;

    logic [DW-1:0] mem_m [FW][FD];
    exp_t          exp_q [$];
    data_vec_t     data_q [$];
    exp_t          mon_e;
    data_vec_t     mon_d;

    function automatic bit in_rng(int c, int lo, int hi);
        return (c >= lo) && (c <= hi);
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, req);
        end
    endtask

    // Monitor: every cycle compare the strobes; on each FIFO shift compare read data.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("fifo_in_en",  bus.fifo_in_en,  {FW{mon_e.fin}});
                check("fifo_out_en", bus.fifo_out_en, {FW{mon_e.fout}});
                check("w_wen",       bus.w_wen,       {FW{mon_e.wwen}});
                check("done",        bus.done,        mon_e.done);
                check("busy_in",     bus.busy_in,     mon_e.bin);
                check("busy_out",    bus.busy_out,    mon_e.bout);
                if (mon_e.rst) begin
                    checks++;
                    if (bus.rd_data !== '0) begin
                        errors++;
                        $display("FAIL rd_data_reset cycle %0d: got %0h expected 0", cyc, bus.rd_data);
                    end
                end
                if (bus.fifo_in_en[0] === 1'b1) begin
                    if (data_q.size() == 0) begin
                        check("rd_data_pending", 64'd0, 64'd1);
                    end else begin
                        mon_d = data_q.pop_front();
                        checks++;
                        if (bus.rd_data !== mon_d) begin
                            errors++;
                            $display("FAIL rd_data cycle %0d: got %0h expected %0h", cyc, bus.rd_data, mon_d);
                        end
                    end
                end
            end
        end
    end

    // One clock of stimulus: predict this cycle's outputs, then drive inputs.
    task automatic step(input logic ie, input logic oe, input logic [FW-1:0] we,
                        input addr_vec_t wa, input data_vec_t wd, input logic rst);
        exp_t      e;
        data_vec_t d;
        if (rst) begin
            fill_s  = -1000;
            drain_s = -1000;
            data_q.delete();
        end
        e.rst  = rst;
        e.fin  = !rst && in_rng(cyc, fill_s + 2, fill_s + FD + 1);
        e.bin  = !rst && in_rng(cyc, fill_s + 1, fill_s + FD + 1);
        e.fout = !rst && in_rng(cyc, drain_s + 1, drain_s + FD);
        e.wwen = !rst && in_rng(cyc, drain_s + 2, drain_s + FD + 1);
        e.done = !rst && (cyc == drain_s + FD + 2);
        e.bout = !rst && in_rng(cyc, drain_s + 1, drain_s + FD + 2);
        exp_q.push_back(e);
        if (!rst && in_rng(cyc, fill_s + 1, fill_s + FD)) begin
            for (int b = 0; b < FW; b++) d[b] = mem_m[b][cyc - fill_s - 1];
            data_q.push_back(d);
        end
        if (!rst && ie && !e.bin) fill_s = cyc;
        if (!rst && oe && !e.bout) drain_s = cyc;
        rstn        = !rst;
        bus.in_en   = ie;
        bus.out_en  = oe;
        bus.wr_en   = rst ? '0 : we;
        bus.wr_addr = wa;
        bus.wr_data = wd;
        if (!rst) begin
            for (int b = 0; b < FW; b++) begin
                if (we[b] && (int'(wa[b]) < FD)) mem_m[b][wa[b]] = wd[b];
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, '0, 1'b0);
    endtask

    initial begin
        addr_vec_t wa;
        data_vec_t wd;
        logic      rst_r;
        bus.in_en   = 1'b0;
        bus.out_en  = 1'b0;
        bus.wr_en   = '0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, '0, '0, 1'b1);
        idle(2);

        // Preload mem[b][i] = 4b + i on every bank.
        for (int i = 0; i < FD; i++) begin
            for (int b = 0; b < FW; b++) begin
                wa[b] = AW'(i);
                wd[b] = DW'(4 * b + i);
            end
            step(1'b0, 1'b0, '1, wa, wd, 1'b0);
        end

        // Fill with a redundant in_en five cycles in.
        step(1'b1, 1'b0, '0, '0, '0, 1'b0);
        for (int j = 1; j < 24; j++) step(j == 5, 1'b0, '0, '0, '0, 1'b0);

        // Plain drain.
        step(1'b0, 1'b1, '0, '0, '0, 1'b0);
        idle(22);

        // Collision: bank 3 address 2 overwritten in the cycle it is read.
        step(1'b1, 1'b0, '0, '0, '0, 1'b0);
        idle(2);
        wa = '0;
        wd = '0;
        wa[3] = AW'(2);
        wd[3] = 16'hBEEF;
        step(1'b0, 1'b0, 16'h0008, wa, wd, 1'b0);
        idle(17);
        step(1'b1, 1'b0, '0, '0, '0, 1'b0);
        idle(20);

        // Reset at drain cycle 8, then a fresh drain.
        step(1'b0, 1'b1, '0, '0, '0, 1'b0);
        idle(7);
        step(1'b0, 1'b0, '0, '0, '0, 1'b1);
        step(1'b0, 1'b0, '0, '0, '0, 1'b1);
        idle(2);
        step(1'b0, 1'b1, '0, '0, '0, 1'b0);
        idle(22);

        // Fill and drain launched together.
        step(1'b1, 1'b1, '0, '0, '0, 1'b0);
        idle(22);

        // Random traffic with concurrent host writes and rare resets.
        for (int i = 0; i < 600; i++) begin
            for (int b = 0; b < FW; b++) begin
                wa[b] = AW'($urandom_range(0, 2 * FD - 1));
                wd[b] = DW'($urandom);
            end
            rst_r = ($urandom_range(0, 149) == 0);
            step($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                 FW'($urandom), wa, wd, rst_r);
        end
        idle(24);

        @(negedge clk);
        check("rd_data_leftover", 64'(data_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/weight_mem_fifo_ctrl.md
WEIGHT_MEM_FIFO_CTRL -- requirements
Module: weight_mem_fifo_ctrl

Interface
REQ-001 SHALL have parameter FIFO_WIDTH, default 16: number of FIFO columns and memory banks.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16: entries per FIFO column, which is also the fill/drain length in cycles.
REQ-003 SHALL have parameter DATA_WIDTH, default 16: weight word width.
REQ-004 SHALL have parameter ADDR_WIDTH, default 8: bank address width; FIFO_DEPTH <= 2^ADDR_WIDTH.
REQ-005 One clock; reset is asynchronous and active-low -- ports clk and rstn.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rstn  input  1  asynchronous active-low reset.
REQ-008 in_en  input  1  single-cycle pulse that starts a memory-to-FIFO fill.
REQ-009 out_en  input  1  single-cycle pulse that starts a FIFO-to-array drain.
REQ-010 wr_en  input  FIFO_WIDTH  per-bank write enable.
REQ-011 wr_addr  input  FIFO_WIDTH x ADDR_WIDTH  per-bank write address.
REQ-012 wr_data  input  FIFO_WIDTH x DATA_WIDTH  per-bank write data.
REQ-013 rd_data  output  FIFO_WIDTH x DATA_WIDTH  per-bank read data, to the weight FIFO input.
REQ-014 fifo_in_en  output  FIFO_WIDTH  per-column FIFO shift enable during fill.
REQ-015 fifo_out_en  output  FIFO_WIDTH  per-column FIFO shift enable during drain.
REQ-016 w_wen  output  FIFO_WIDTH  per-row weight-write strobe to the systolic array.
REQ-017 done  output  1  one-cycle pulse marking drain completion.
REQ-018 busy_in / busy_out  output  1 each  high while a fill / drain sequence is active.

Function
REQ-019 Memory: FIFO_WIDTH independent banks of 2^ADDR_WIDTH x DATA_WIDTH; write is synchronous, with bank b written at wr_addr[b] when wr_en[b]=1.
REQ-020 Memory read: synchronous, 1-cycle latency; rd_data[b] = mem[b][rd_addr] registered at the edge where mem_rd_en is high, and rd_data holds otherwise.
REQ-021 Read and write to the same bank and address in the same cycle: rd_data SHALL return the old contents (read-before-write).
REQ-022 Fill: the in_en pulse while idle starts the fill; for cycles k=0..FIFO_DEPTH-1 after it, mem_rd_en=all ones and rd_addr=k for all banks.
REQ-023 Fill: fifo_in_en SHALL equal all ones exactly one cycle after each read, i.e. FIFO_DEPTH consecutive cycles aligned with valid rd_data; it is 0 otherwise.
REQ-024 Fill: busy_in is high from the cycle after in_en until the last fifo_in_en cycle inclusive.
REQ-025 Drain: the out_en pulse while idle starts the drain; fifo_out_en=all ones for FIFO_DEPTH consecutive cycles starting the cycle after out_en.
REQ-026 Drain: w_wen SHALL be all ones one cycle after each fifo_out_en cycle, matching the registered FIFO output.
REQ-027 done SHALL pulse high for one cycle, in the cycle after the last w_wen.
REQ-028 in_en asserted while busy_in, or out_en while busy_out, SHALL be ignored.
REQ-029 Fill and drain are independent and may overlap; host writes proceed concurrently with a fill.
REQ-030 Counters SHALL be ceil(log2(FIFO_DEPTH+1)) bits and SHALL not wrap.
REQ-031 rd_addr SHALL be zero-extended to ADDR_WIDTH.

Reset
REQ-032 While rstn=0: counters, fifo_in_en, fifo_out_en, w_wen, done, busy_in, busy_out and rd_data SHALL all be 0; memory contents are not reset.
REQ-033 Reset mid-sequence SHALL abort the sequence; after release the block is idle and needs a new in_en/out_en pulse.

Structure
REQ-034 A shared package SHALL hold the default parameter constants and the derived count-width function.
REQ-035 The block SHALL use three sub-modules: mem_arr (banks), fifo_in_ctrl (fill sequencer), and fifo_out_ctrl (drain sequencer plus done).

Verification
REQ-036 Write scenario: write mem[b][i]=4b+i for i=0..15 on all banks, then a fill -> rd_data[b] = 4b+k one cycle after rd_addr=k, and fifo_in_en high for exactly 16 cycles.
REQ-037 Drain scenario: out_en pulse -> fifo_out_en high for cycles 1..16, w_wen high for cycles 2..17, and done high only at cycle 18.
REQ-038 Ignore scenario: a second in_en pulse at fill cycle 5 -> no extension, with still exactly 16 fifo_in_en cycles.
REQ-039 Collision scenario: write bank 3 at address 2 with 0xBEEF while it is read in the same cycle -> the old value is returned, and 0xBEEF is returned on the next read.
REQ-040 Reset scenario: rstn low during drain cycle 8 -> all outputs 0 and done never pulses; a fresh out_en then completes normally.
REQ-041 Overlap scenario: in_en and out_en pulsed in the same cycle -> both sequences complete with correct cycle counts.
